delay_line_vec: RTL and testbench
=================================

// Module: delay_line_vec
// PURPOSE
// - Parametrised multi-stage delay line for the paired vector operands (a, b) of the filter datapath.
// - Generalises the single-register delay element:
//   - configurable depth
//   - per-stage valid tracking
//   - stall (enable)
//   - flush
//   - run-time tap selection
// - Sits between the sample source and the lattice/recursive stages; supplies a[n-k], b[n-k] aligned to valid.
// PARAMETERS
// - REG_WIDTH  16  bit width of each vector element
// - VECTOR     2   elements per operand vector (a and b each)
// - DEPTH      4   number of delay stages (>= 2)
// - TW  = $clog2(DEPTH)    tap select width (localparam)
// - CW  = $clog2(DEPTH+1)  fill count width (localparam)
// PORTS
// - clk       in   1                          single clock, all state on posedge
// - rst       in   1                          synchronous, active-high reset
// - en        in   1                          advance pipeline by one stage this cycle
// - flush     in   1                          invalidate all stages (data retained, valid cleared)
// - in_valid  in   1                          a_in/b_in carry a real sample
// - a_in      in   [REG_WIDTH-1:0] [VECTOR]   operand a, current sample
// - b_in      in   [REG_WIDTH-1:0] [VECTOR]   operand b, current sample
// - tap_sel   in   TW                         output tap: value k selects stage k (delay k+1 advances)
// - a_out     out  [REG_WIDTH-1:0] [VECTOR]   a from selected stage
// - b_out     out  [REG_WIDTH-1:0] [VECTOR]   b from selected stage
// - out_valid out  1                          valid bit of selected stage
// - fill      out  CW                         count of valid stages, 0..DEPTH
// - full      out  1                          fill == DEPTH
// BEHAVIOUR
// - Storage:
//   - stages s[0..DEPTH-1], each holds a vector, b vector and valid bit v.
//   - s[0] is the newest stage.
// - Reset (rst=1 at posedge):
//   - all data regs <= 0; all v <= 0; fill <= 0.
//   - rst dominates en and flush.
//   - Outputs therefore read 0, out_valid=0, full=0 the cycle after reset.
// - Advance (en=1, flush=0):
//   - s[0] <= {a_in, b_in, in_valid}.
//   - s[i] <= s[i-1] for i=1..DEPTH-1.
//   - Oldest stage contents are discarded.
// - Stall (en=0, flush=0):
//   - all stages hold; fill holds.
//   - in_valid and the a_in/b_in data are ignored.
// - Flush (flush=1):
//   - all v <= 0, fill <= 0.
//   - Data regs are shifted if en=1, held if en=0.
//   - The incoming sample is NOT captured as valid, even when in_valid=1 and en=1 (flush wins).
// - Fill count:
//   - fill = number of stages with v=1, maintained as a registered counter.
//   - on advance: fill_next = fill + in_valid - v[DEPTH-1].
//   - never exceeds DEPTH and never underflows.
//   - in_valid=1 with full=1 keeps fill at DEPTH: the oldest valid sample leaves as the new one enters.
// - Output mux:
//   - combinational from registers: {a_out, b_out, out_valid} = s[tap_sel].
//   - latency = tap_sel+1 advancing cycles from input to output.
//   - tap_sel may change any cycle; output follows in the same cycle.
//   - tap_sel >= DEPTH (non-power-of-2 DEPTH) selects s[DEPTH-1].
// - Width rules:
//   - pure storage, no arithmetic on data.
//   - vector elements are carried bit-exact, element order preserved (index 0 -> index 0).
// - Mid-operation reset or flush: samples in flight are lost; no partial state survives.
// - No initial blocks; reset is the only initialisation.
// TESTING
// - Reset:
//   - stimulus: load stages with nonzero data, assert rst 1 cycle with en=1, flush=1.
//   - required: next cycle all taps read 0, out_valid=0, fill=0.
// - Latency sweep:
//   - stimulus: DEPTH=4, en=1, a_in[0]=16'h1234 for one cycle with in_valid=1.
//   - required: for tap_sel=k, a_out[0]=16'h1234 with out_valid=1 exactly k+1 cycles later.
// - Stall:
//   - stimulus: push 3 valid samples (0x11, 0x22, 0x33), then en=0 for 5 cycles while a_in toggles.
//   - required: stage contents and fill=3 unchanged; on resume, order continues 0x11->0x22->0x33.
// - Full wrap:
//   - stimulus: 6 consecutive valid samples into DEPTH=4.
//   - required: fill saturates at 4, full=1; tap 3 shows samples 1,2 leaving in order, no fill overflow.
// - Flush with input:
//   - stimulus: fill=4, flush=1, en=1, in_valid=1, a_in=0xABCD.
//   - required: next cycle fill=0, every tap out_valid=0.
// - Bubbles:
//   - stimulus: pattern in_valid=1,0,1,1 with en=1.
//   - required: fill goes 1,1,2,3 and tap 3 out_valid pattern 1,0,1,1 delayed by 4 cycles.

Source files
------------

// File: rtl/delay_line_vec.sv
// Multi-stage delay line for paired operand vectors with per-stage valid, stall, flush and run-time tap select.
// Latency tap_sel+1 advancing cycles; en=0 stalls every stage, flush clears valids (data still shifts when en=1).
module delay_line_vec #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 2,
    parameter int DEPTH     = 4,
    localparam int TW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                flush,
    input  logic                                in_valid,
    input  logic [VECTOR-1:0][REG_WIDTH-1:0]    a_in,
    input  logic [VECTOR-1:0][REG_WIDTH-1:0]    b_in,
    input  logic [TW-1:0]                       tap_sel,
    output logic [VECTOR-1:0][REG_WIDTH-1:0]    a_out,
    output logic [VECTOR-1:0][REG_WIDTH-1:0]    b_out,
    output logic                                out_valid,
    output logic [CW-1:0]                       fill,
    output logic                                full
);

    logic [VECTOR-1:0][REG_WIDTH-1:0] a_q [DEPTH];
    logic [VECTOR-1:0][REG_WIDTH-1:0] b_q [DEPTH];
    logic [VECTOR-1:0][REG_WIDTH-1:0] a_d [DEPTH];
    logic [VECTOR-1:0][REG_WIDTH-1:0] b_d [DEPTH];
    logic [DEPTH-1:0]                 v_q;
    logic [DEPTH-1:0]                 v_d;
    logic [CW-1:0]                    fill_q;
    logic [CW-1:0]                    fill_d;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        v_d    = v_q;
        fill_d = fill_q;
        if (en) begin
            a_d[0] = a_in;
            b_d[0] = b_in;
            v_d    = {v_q[DEPTH-2:0], in_valid};
            for (int i = 1; i < DEPTH; i++) begin
                a_d[i] = a_q[i-1];
                b_d[i] = b_q[i-1];
            end
            // The valid leaving the oldest stage balances the one entering, so fill cannot pass DEPTH.
            fill_d = fill_q + CW'(in_valid) - CW'(v_q[DEPTH-1]);
        end
        if (flush) begin
            v_d    = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            v_q    <= '0;
            fill_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
            v_q    <= v_d;
            fill_q <= fill_d;
        end
    end

    // Unmatched tap values (only possible with non-power-of-2 DEPTH) fall through to the oldest stage.
    always_comb begin
        a_out     = a_q[DEPTH-1];
        b_out     = b_q[DEPTH-1];
        out_valid = v_q[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TW'(i)) begin
                a_out     = a_q[i];
                b_out     = b_q[i];
                out_valid = v_q[i];
            end
        end
    end

    assign fill = fill_q;
    assign full = (fill_q == CW'(DEPTH));

endmodule

// File: tb/tb_delay_line_vec.sv
// Directed bench for delay_line_vec (DEPTH=4): expected observations are queued by the driver, checked by a monitor.
module tb_delay_line_vec;

    logic              clk = 1'b0;
    logic              rst, en, flush, in_valid;
    logic [1:0][15:0]  a_in, b_in, a_out, b_out;
    logic [1:0]        tap_sel;
    logic              out_valid;
    logic [2:0]        fill;
    logic              full;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        ov;
        logic [2:0]  fill;
        logic        full;
        logic        chk;
        logic        zero;
        logic [15:0] a0;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    delay_line_vec #(.REG_WIDTH(16), .VECTOR(2), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .a_in(a_in), .b_in(b_in), .tap_sel(tap_sel),
        .a_out(a_out), .b_out(b_out), .out_valid(out_valid),
        .fill(fill), .full(full)
    );

    always #5 clk = ~clk;

    // Every sample is self-describing: the other three elements derive from a[0].
    task automatic drive(input logic r, input logic e, input logic f, input logic iv, input logic [15:0] a);
        rst      = r;
        en       = e;
        flush    = f;
        in_valid = iv;
        a_in[0]  = a;
        a_in[1]  = ~a;
        b_in[0]  = a ^ 16'h5A5A;
        b_in[1]  = a + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] tap, input logic ov,
                              input logic [2:0] fl, input logic fu, input logic chk,
                              input logic zero, input logic [15:0] a0);
        exp_t e;
        tap_sel = tap;
        e.ov = ov; e.fill = fl; e.full = fu; e.chk = chk; e.zero = zero; e.a0 = a0;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t       e;
        string      nm;
        logic [1:0][15:0] ea, eb;
        logic       ok;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.zero) begin
                    ea = '0;
                    eb = '0;
                end else begin
                    ea[0] = e.a0;
                    ea[1] = ~e.a0;
                    eb[0] = e.a0 ^ 16'h5A5A;
                    eb[1] = e.a0 + 16'd1;
                end
                ok = (out_valid === e.ov) && (fill === e.fill) && (full === e.full);
                if (e.chk || e.zero)
                    ok = ok && (a_out === ea) && (b_out === eb);
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL %s tap=%0d: got a=%h b=%h ov=%b fill=%0d full=%b, want a=%h b=%h ov=%b fill=%0d full=%b (data checked=%b)",
                             nm, tap_sel, a_out, b_out, out_valid, fill, full,
                             ea, eb, e.ov, e.fill, e.full, e.chk || e.zero);
                end
            end
        end
    end

    initial begin : stim
        int w;
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
        a_in = '0; b_in = '0; tap_sel = 2'd0;

        // Reset from power-up, then load nonzero data and reset again with en/flush high.
        drive(1, 0, 0, 0, 16'h0000);
        drive(1, 0, 0, 0, 16'h0000);
        expect_out("por", 2'd0, 0, 3'd0, 0, 0, 1, 16'h0);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 0, 1, 16'hA000 + 16'(i));
            expect_out("load", 2'd0, 1, 3'(i), (i == 4), 1, 0, 16'hA000 + 16'(i));
        end
        drive(1, 1, 1, 1, 16'hBEEF);
        expect_out("rst_tap0", 2'd0, 0, 3'd0, 0, 0, 1, 16'h0);
        for (int k = 1; k < 4; k++) begin
            drive(0, 0, 0, 1, 16'h7777);
            expect_out("rst_tap", 2'(k), 0, 3'd0, 0, 0, 1, 16'h0);
        end

        // Latency sweep: a single valid sample appears on tap k exactly k+1 advances later.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 0, 16'h0000);
            expect_out("lat_flush", 2'(k), 0, 3'd0, 0, 0, 0, 16'h0);
            for (int c = 1; c <= 4; c++) begin
                if (c == 1) drive(0, 1, 0, 1, 16'h1234);
                else        drive(0, 1, 0, 0, 16'h0000);
                expect_out("latency", 2'(k), (c == k + 1), 3'd1, 0, (c == k + 1), 0, 16'h1234);
            end
        end

        // Stall: three samples held through five en=0 cycles with toggling input.
        drive(0, 1, 1, 0, 16'h0000);
        expect_out("st_flush", 2'd0, 0, 3'd0, 0, 0, 0, 16'h0);
        drive(0, 1, 0, 1, 16'h0011);
        expect_out("st_push", 2'd0, 1, 3'd1, 0, 1, 0, 16'h0011);
        drive(0, 1, 0, 1, 16'h0022);
        expect_out("st_push", 2'd0, 1, 3'd2, 0, 1, 0, 16'h0022);
        drive(0, 1, 0, 1, 16'h0033);
        expect_out("st_push", 2'd0, 1, 3'd3, 0, 1, 0, 16'h0033);
        drive(0, 0, 0, 1, 16'hF0F0);
        expect_out("stall", 2'd0, 1, 3'd3, 0, 1, 0, 16'h0033);
        drive(0, 0, 0, 1, 16'h0F0F);
        expect_out("stall", 2'd1, 1, 3'd3, 0, 1, 0, 16'h0022);
        drive(0, 0, 0, 1, 16'hF0F0);
        expect_out("stall", 2'd2, 1, 3'd3, 0, 1, 0, 16'h0011);
        drive(0, 0, 0, 1, 16'h0F0F);
        expect_out("stall", 2'd3, 0, 3'd3, 0, 0, 0, 16'h0);
        drive(0, 0, 0, 1, 16'hF0F0);
        expect_out("stall", 2'd0, 1, 3'd3, 0, 1, 0, 16'h0033);
        drive(0, 1, 0, 0, 16'h0000);
        expect_out("resume", 2'd3, 1, 3'd3, 0, 1, 0, 16'h0011);
        drive(0, 1, 0, 0, 16'h0000);
        expect_out("resume", 2'd3, 1, 3'd2, 0, 1, 0, 16'h0022);
        drive(0, 1, 0, 0, 16'h0000);
        expect_out("resume", 2'd3, 1, 3'd1, 0, 1, 0, 16'h0033);

        // Full wrap: six samples into four stages, then one more while full.
        drive(0, 1, 1, 0, 16'h0000);
        expect_out("wr_flush", 2'd3, 0, 3'd0, 0, 0, 0, 16'h0);
        for (int i = 1; i <= 7; i++) begin
            drive(0, 1, 0, 1, 16'h0101 * 16'(i));
            expect_out("wrap", 2'd3, (i >= 4), (i >= 4) ? 3'd4 : 3'(i), (i >= 4),
                       (i >= 4), 0, 16'h0101 * 16'(i - 3));
        end

        // Flush while full with a valid incoming sample: nothing survives as valid.
        drive(0, 1, 1, 1, 16'hABCD);
        expect_out("flush_in", 2'd0, 0, 3'd0, 0, 0, 0, 16'h0);
        for (int k = 1; k < 4; k++) begin
            drive(0, 0, 0, 1, 16'h5555);
            expect_out("flush_in", 2'(k), 0, 3'd0, 0, 0, 0, 16'h0);
        end

        // Bubbles: in_valid 1,0,1,1 then idle; watch tap 3 and the fill counter.
        drive(0, 1, 0, 1, 16'hC001);
        expect_out("bubble", 2'd3, 0, 3'd1, 0, 0, 0, 16'h0);
        drive(0, 1, 0, 0, 16'hC002);
        expect_out("bubble", 2'd3, 0, 3'd1, 0, 0, 0, 16'h0);
        drive(0, 1, 0, 1, 16'hC003);
        expect_out("bubble", 2'd3, 0, 3'd2, 0, 0, 0, 16'h0);
        drive(0, 1, 0, 1, 16'hC004);
        expect_out("bubble", 2'd3, 1, 3'd3, 0, 1, 0, 16'hC001);
        drive(0, 1, 0, 0, 16'h0000);
        expect_out("bubble", 2'd3, 0, 3'd2, 0, 0, 0, 16'h0);
        drive(0, 1, 0, 0, 16'h0000);
        expect_out("bubble", 2'd3, 1, 3'd2, 0, 1, 0, 16'hC003);
        drive(0, 1, 0, 0, 16'h0000);
        expect_out("bubble", 2'd3, 1, 3'd1, 0, 1, 0, 16'hC004);
        drive(0, 1, 0, 0, 16'h0000);
        expect_out("bubble", 2'd3, 0, 3'd0, 0, 0, 0, 16'h0);

        w = 0;
        while (exp_q.size() != 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
